axis_fifo_ctrl: RTL and testbench



---
 rtl/axis_fifo_pkg.sv | 24 ++
 rtl/axis_fifo_outbuf.sv | 56 +++++
 rtl/axis_fifo_ctrl.sv | 107 ++++++++++
 tb/tb_axis_fifo_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_fifo_pkg.sv
// Shared helpers for the AXI-Stream FIFO controller: width math, output-buffer
// sizing and the set of supported RAM read latencies.
package axis_fifo_pkg;

  localparam int RL_MIN = 1;
  localparam int RL_MAX = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Enough slots to cover every read in flight plus one beat of pop slack.
  function automatic int ob_depth(input int read_latency);
    return read_latency + 2;
  endfunction

  function automatic bit rl_legal(input int read_latency);
    return (read_latency >= RL_MIN) && (read_latency <= RL_MAX);
  endfunction

endpackage

// File: rtl/axis_fifo_outbuf.sv
// Small register FIFO that catches RAM read data and presents it on m_axis.
// Push and pop may coincide; the controller's credit check prevents overflow.
module axis_fifo_outbuf
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int OB_DEPTH   = 4,
  parameter int CW         = clog2(OB_DEPTH + 1)
) (
  input  logic                  clka,
  input  logic                  rstb,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CW-1:0]         ob_count
);

  localparam int PW = (OB_DEPTH > 1) ? clog2(OB_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [OB_DEPTH];
  logic [PW-1:0]         wr_idx;
  logic [PW-1:0]         rd_idx;
  logic                  pop;

  // OB_DEPTH need not be a power of two, so indices wrap explicitly.
  function automatic logic [PW-1:0] idx_inc(input logic [PW-1:0] idx);
    return (idx == PW'(OB_DEPTH - 1)) ? '0 : idx + PW'(1);
  endfunction

  assign out_valid = (ob_count != '0);
  assign pop       = out_valid & pop_ready;
  assign out_data  = mem[rd_idx];

  always_ff @(posedge clka) begin
    if (push) mem[wr_idx] <= push_data;
  end

  always_ff @(posedge clka) begin
    if (rstb) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      ob_count <= '0;
    end else begin
      if (push) wr_idx <= idx_inc(wr_idx);
      if (pop)  rd_idx <= idx_inc(rd_idx);
      case ({push, pop})
        2'b10:   ob_count <= ob_count + CW'(1);
        2'b01:   ob_count <= ob_count - CW'(1);
        default: ob_count <= ob_count;
      endcase
    end
  end

endmodule

// File: rtl/axis_fifo_ctrl.sv
// AXI-Stream FIFO controller around an external simple-dual-port RAM: owns the
// pointers and occupancy, prefetches reads and buffers returned data.
module axis_fifo_ctrl
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH        = 512,
  parameter int READ_LATENCY = 2,
  parameter int AW           = clog2(DEPTH)
) (
  input  logic                  clka,
  input  logic                  rstb,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [AW:0]           count,
  output logic [AW-1:0]         ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic                  ram_wea,
  output logic [AW-1:0]         ram_addrb,
  output logic                  ram_enb,
  output logic                  ram_regceb,
  input  logic [DATA_WIDTH-1:0] ram_doutb
);

  localparam int OB_DEPTH = ob_depth(READ_LATENCY);
  localparam int CW       = clog2(OB_DEPTH + 1);

  if (!rl_legal(READ_LATENCY)) begin : g_bad_latency
    $error("axis_fifo_ctrl: READ_LATENCY must be 1 or 2");
  end
  if ((DEPTH < 4) || ((1 << AW) != DEPTH)) begin : g_bad_depth
    $error("axis_fifo_ctrl: DEPTH must be a power of two and at least 4");
  end

  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW:0]             count_nxt;
  logic [READ_LATENCY-1:0] rd_vld_p;
  logic [CW-1:0]           inflight;
  logic [CW-1:0]           ob_count;
  logic                    wr_en;
  logic                    rd_issue;

  assign wr_en = s_axis_tvalid & s_axis_tready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + CW'(rd_vld_p[i]);
    end
  end

  // Credit uses the registered ob_count: a same-cycle pop is not counted as
  // free space, which still leaves enough slack for one beat per cycle.
  assign rd_issue = ~rstb & (count != '0) &
                    (((CW + 1)'(inflight) + (CW + 1)'(ob_count)) < (CW + 1)'(OB_DEPTH));

  always_comb begin
    count_nxt = count;
    if (wr_en && !rd_issue)      count_nxt = count + (AW + 1)'(1);
    else if (rd_issue && !wr_en) count_nxt = count - (AW + 1)'(1);
  end

  always_ff @(posedge clka) begin
    if (rstb) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      s_axis_tready <= 1'b0;
      rd_vld_p      <= '0;
    end else begin
      if (wr_en)    wr_ptr <= wr_ptr + AW'(1);
      if (rd_issue) rd_ptr <= rd_ptr + AW'(1);
      count         <= count_nxt;
      s_axis_tready <= (count_nxt < (AW + 1)'(DEPTH));
      rd_vld_p      <= READ_LATENCY'({rd_vld_p, rd_issue});
    end
  end

  assign ram_wea    = wr_en;
  assign ram_addra  = wr_ptr;
  assign ram_dina   = s_axis_tdata;
  assign ram_enb    = rd_issue;
  assign ram_addrb  = rd_ptr;
  assign ram_regceb = 1'b1;

  // Stage boundary: the oldest read tag marks RAM data valid this cycle.
  axis_fifo_outbuf #(
    .DATA_WIDTH (DATA_WIDTH),
    .OB_DEPTH   (OB_DEPTH),
    .CW         (CW)
  ) u_outbuf (
    .clka      (clka),
    .rstb      (rstb),
    .push      (rd_vld_p[READ_LATENCY-1]),
    .push_data (ram_doutb),
    .pop_ready (m_axis_tready),
    .out_valid (m_axis_tvalid),
    .out_data  (m_axis_tdata),
    .ob_count  (ob_count)
  );

endmodule

// File: tb/tb_axis_fifo_ctrl.sv
// Bench for axis_fifo_ctrl: two instances (read latency 2 and 1, DEPTH 16)
// share stimulus, each with its own RAM model and in-order sequence scoreboard.
module tb_axis_fifo_ctrl;

  localparam int DEPTH = 16;
  localparam int DW    = 32;

  logic clka = 1'b0;
  logic rstb = 1'b1;
  logic s_tvalid = 1'b0;
  logic m_tready = 1'b0;

  logic [DW-1:0] s_tdata [2];
  logic          s_tready [2];
  logic [DW-1:0] m_tdata [2];
  logic          m_tvalid [2];
  logic [4:0]    cnt [2];
  logic [3:0]    addra [2];
  logic [3:0]    addrb [2];
  logic [DW-1:0] dina [2];
  logic [DW-1:0] doutb [2];
  logic          wea [2];
  logic          enb [2];
  logic          regceb [2];

  int in_seq [2];
  int exp_out [2];
  int out_cnt [2];
  logic          prev_v [2];
  logic          prev_r [2];
  logic [DW-1:0] prev_d [2];
  logic prev_rst = 1'b1;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clka = ~clka;

  // Payload of sequence number n; odd multiplier keeps it one-to-one.
  function automatic logic [DW-1:0] beat(input int n);
    return (DW'(n) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam int L = (k == 0) ? 2 : 1;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] q1;
    logic [DW-1:0] q2;

    assign s_tdata[k] = beat(in_seq[k]);

    always @(posedge clka) begin
      if (wea[k]) mem[addra[k]] <= dina[k];
      if (enb[k]) q1 <= mem[addrb[k]];
      if (rstb) q2 <= '0;
      else if (regceb[k]) q2 <= q1;
    end
    assign doutb[k] = (L == 2) ? q2 : q1;

    axis_fifo_ctrl #(
      .DATA_WIDTH   (DW),
      .DEPTH        (DEPTH),
      .READ_LATENCY (L)
    ) u_dut (
      .clka          (clka),
      .rstb          (rstb),
      .s_axis_tdata  (s_tdata[k]),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready[k]),
      .m_axis_tdata  (m_tdata[k]),
      .m_axis_tvalid (m_tvalid[k]),
      .m_axis_tready (m_tready),
      .count         (cnt[k]),
      .ram_addra     (addra[k]),
      .ram_dina      (dina[k]),
      .ram_wea       (wea[k]),
      .ram_addrb     (addrb[k]),
      .ram_enb       (enb[k]),
      .ram_regceb    (regceb[k]),
      .ram_doutb     (doutb[k])
    );
  end

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk_le(input string name, input longint a, input longint b);
    n_checks++;
    if (a > b) begin
      n_errors++;
      $display("FAIL %s: value %0d above limit %0d (cycle %0d)", name, a, b, cyc);
    end
  endtask

  // Check the current cycle against the model, then advance one clock.
  task automatic tick();
    logic hs_in [2];
    logic hs_out [2];
    logic was_rst;
    int occ;
    for (int k = 0; k < 2; k++) begin
      if (!rstb && m_tvalid[k] && m_tready)
        chk($sformatf("data_order[%0d]", k), m_tdata[k], beat(exp_out[k]));
      if (!rstb && !prev_rst) begin
        occ = in_seq[k] - exp_out[k];
        chk($sformatf("tready_vs_count[%0d]", k), s_tready[k], cnt[k] < DEPTH);
        chk_le($sformatf("count_cap[%0d]", k), cnt[k], DEPTH);
        chk_le($sformatf("count_le_held[%0d]", k), cnt[k], occ);
        chk_le($sformatf("held_le_count_ob[%0d]", k), occ, cnt[k] + lat(k) + 2);
      end
      if (!prev_rst && prev_v[k] && !prev_r[k]) begin
        chk($sformatf("hold_valid[%0d]", k), m_tvalid[k], 1);
        chk($sformatf("hold_data[%0d]", k), m_tdata[k], prev_d[k]);
      end
      hs_in[k]  = s_tvalid && s_tready[k];
      hs_out[k] = m_tvalid[k] && m_tready;
      prev_v[k] = m_tvalid[k];
      prev_r[k] = m_tready;
      prev_d[k] = m_tdata[k];
    end
    was_rst = rstb;
    @(posedge clka);
    #1;
    cyc++;
    prev_rst = was_rst;
    for (int k = 0; k < 2; k++) begin
      if (was_rst) begin
        exp_out[k] = in_seq[k];
      end else begin
        if (hs_in[k]) in_seq[k]++;
        if (hs_out[k]) begin
          exp_out[k]++;
          out_cnt[k]++;
        end
      end
    end
  endtask

  task automatic drain(input string tag, input int n);
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (n) tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_all_out[%0d]", tag, k), exp_out[k], in_seq[k]);
      chk($sformatf("%s_empty_valid[%0d]", tag, k), m_tvalid[k], 0);
      chk($sformatf("%s_empty_count[%0d]", tag, k), cnt[k], 0);
    end
  endtask

  // One beat into an empty FIFO: valid exactly at cycle L+2, count 1 then 0.
  task automatic single_beat(input string tag, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    logic [DW-1:0] e [2];
    e[0] = e0;
    e[1] = e1;
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("%s_valid_c%0d[%0d]", tag, c, k), m_tvalid[k], (c == lat(k) + 2));
        chk($sformatf("%s_count_c%0d[%0d]", tag, c, k), cnt[k], (c == 1));
        if (c == lat(k) + 2)
          chk($sformatf("%s_data[%0d]", tag, k), m_tdata[k], e[k]);
      end
      tick();
    end
  endtask

  initial begin
    int st [2];
    int guard;
    for (int k = 0; k < 2; k++) begin
      in_seq[k]  = 0;
      exp_out[k] = 0;
      out_cnt[k] = 0;
      prev_v[k]  = 1'b0;
      prev_r[k]  = 1'b0;
      prev_d[k]  = '0;
    end

    repeat (3) tick();
    rstb = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_tvalid[%0d]", k), m_tvalid[k], 0);
      chk($sformatf("rst_count[%0d]", k), cnt[k], 0);
      chk($sformatf("rst_tready[%0d]", k), s_tready[k], 0);
      chk($sformatf("rst_wea[%0d]", k), wea[k], 0);
      chk($sformatf("rst_enb[%0d]", k), enb[k], 0);
    end
    tick();
    for (int k = 0; k < 2; k++) chk($sformatf("tready_after_rst[%0d]", k), s_tready[k], 1);

    single_beat("single", 32'h5A5A0F0F, 32'h5A5A0F0F);

    // Fill with the sink stalled: RAM depth plus output buffer.
    st[0] = in_seq[0];
    st[1] = in_seq[1];
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    repeat (40) tick();
    chk("fill_accepted[0]", in_seq[0] - st[0], 20);
    chk("fill_accepted[1]", in_seq[1] - st[1], 19);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("fill_tready[%0d]", k), s_tready[k], 0);
      chk($sformatf("fill_count[%0d]", k), cnt[k], DEPTH);
    end
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    st[0] = in_seq[0];
    st[1] = in_seq[1];
    repeat (10) tick();
    for (int k = 0; k < 2; k++)
      chk($sformatf("one_pop_one_in[%0d]", k), in_seq[k] - st[k], 1);
    drain("fill", 40);

    // Streaming with both sides always ready.
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    repeat (10) tick();
    st[0] = out_cnt[0];
    st[1] = out_cnt[1];
    repeat (990) tick();
    for (int k = 0; k < 2; k++)
      chk($sformatf("stream_rate[%0d]", k), out_cnt[k] - st[k], 990);
    drain("stream", 20);

    // Random back-pressure on both sides.
    st[0] = in_seq[0];
    guard = 0;
    while ((in_seq[0] - st[0] < 5000) && (guard < 40000)) begin
      s_tvalid = 1'($urandom_range(0, 1));
      m_tready = 1'($urandom_range(0, 1));
      tick();
      guard++;
    end
    chk("random_beats_done", (in_seq[0] - st[0]) >= 5000, 1);
    drain("random", 60);

    // Wrap-around with instance 0 RAM occupancy held between 10 and 14.
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    guard = 0;
    while ((cnt[0] < 12) && (guard < 100)) begin
      tick();
      guard++;
    end
    chk("wrap_reached_12", cnt[0], 12);
    st[0] = out_cnt[0];
    guard = 0;
    while ((out_cnt[0] - st[0] < 100) && (guard < 3000)) begin
      chk_le("wrap_occ_hi", cnt[0], 14);
      chk_le("wrap_occ_lo", 10, cnt[0]);
      s_tvalid = (cnt[0] < 11) ? 1'b1 : (cnt[0] > 13) ? 1'b0 : 1'($urandom_range(0, 1));
      m_tready = 1'($urandom_range(0, 1));
      tick();
      guard++;
    end
    chk("wrap_beats_done", (out_cnt[0] - st[0]) >= 100, 1);
    drain("wrap", 60);

    // Reset with words stored and reads in flight.
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    repeat (14) tick();
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (2) tick();
    rstb = 1'b1;
    m_tready = 1'b0;
    tick();
    rstb = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("midrst_tvalid[%0d]", k), m_tvalid[k], 0);
      chk($sformatf("midrst_count[%0d]", k), cnt[k], 0);
    end
    m_tready = 1'b1;
    repeat (2) tick();
    single_beat("post_rst", beat(in_seq[0]), beat(in_seq[1]));
    drain("post_rst", 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
